// File: rtl/sccb_cmd_regs_pkg.sv
// sccb_cmd_regs_pkg: register offsets, STATUS/CTRL bit positions, ID constant and command layout
package sccb_cmd_regs_pkg;
  localparam logic [7:0] REG_ID       = 8'h00;
  localparam logic [7:0] REG_CTRL     = 8'h01;
  localparam logic [7:0] REG_STATUS   = 8'h02;
  localparam logic [7:0] REG_PUSH     = 8'h03;
  localparam logic [7:0] REG_RX       = 8'h04;
  localparam logic [7:0] REG_LEVEL    = 8'h05;
  localparam logic [7:0] REG_IRQ_MASK = 8'h06;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_BUSY     = 2;
  localparam int ST_RX_VALID = 3;
  localparam int ST_OVF      = 8;
  localparam int ST_NACK     = 9;
  localparam int ST_RX_OVR   = 10;
  localparam logic [15:0] ID_MAGIC = 16'h5CCB;
  localparam logic [7:0]  ID_REV   = 8'h01;
  typedef struct packed {
    logic       rd;
    logic [7:0] slave_id;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } sccb_cmd_t;
  localparam int CMD_W = $bits(sccb_cmd_t);
  function automatic logic [31:0] id_word(input int depth);
    return {ID_MAGIC, depth[7:0], ID_REV};
  endfunction
endpackage

// File: rtl/sccb_sync_fifo.sv
// sccb_sync_fifo: synchronous FIFO with flush; push at full only lands when a pop frees the slot
module sccb_sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign level_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = flush_i ? '0 : do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = flush_i ? '0 : do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = flush_i ? '0 : (do_push && !do_pop) ? cnt_q + 1'b1 : (do_pop && !do_push) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
endmodule

// File: rtl/sccb_cmd_regs.sv
// sccb_cmd_regs: dev-bus register block queuing SCCB commands and holding rx/status; `SCCB_CMD_REGS_IRQ_EN adds irq_o and IRQ_MASK
module sccb_cmd_regs
  import sccb_cmd_regs_pkg::*;
#(
  parameter logic [7:0] DEV_INDEX  = 8'h01,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        dev_index_i,
  input  logic [7:0]        dev_cmd_i,
  input  logic [31:0]       dev_wdata_i,
  input  logic [3:0]        dev_wvalid_be_i,
  input  logic              dev_wvalid_i,
  input  logic              dev_rvalid_i,
  output logic [31:0]       dev_rdata_o,
  output logic              cmd_valid_o,
  output logic [CMD_W-1:0]  cmd_data_o,
  input  logic              cmd_ready_i,
  input  logic              rsp_valid_i,
  input  logic [7:0]        rsp_data_i,
  input  logic              rsp_nack_i,
  input  logic              busy_i
`ifdef SCCB_CMD_REGS_IRQ_EN
  ,output logic             irq_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] ID_WORD = id_word(FIFO_DEPTH);
  logic sel, wr, rd, push, pop, flush, w1c, rx_clr, ovf_set, empty, full;
  logic [AW:0] level;
  logic [31:0] status, reg_val, mask_rd;
  logic [31:0] rdata_q, rdata_d;
  logic en_q, en_d, ovf_q, ovf_d, nack_q, nack_d, rx_ovr_q, rx_ovr_d, rx_valid_q, rx_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic unused_wdata;
  assign unused_wdata = ^dev_wdata_i[31:CMD_W];
  assign cmd_valid_o  = !empty && en_q;
  assign pop          = cmd_valid_o && cmd_ready_i;
  assign dev_rdata_o  = rdata_q;
  sccb_sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (dev_wdata_i[CMD_W-1:0]),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (cmd_data_o),
    .empty_o (empty),
    .full_o  (full),
    .level_o (level)
  );
  always_comb begin
    sel        = dev_index_i == DEV_INDEX;
    wr         = dev_wvalid_i && sel;
    rd         = dev_rvalid_i && sel;
    push       = wr && dev_cmd_i == REG_PUSH && &dev_wvalid_be_i;
    flush      = wr && dev_cmd_i == REG_CTRL && dev_wvalid_be_i[0] && dev_wdata_i[CTRL_FLUSH];
    w1c        = wr && dev_cmd_i == REG_STATUS && dev_wvalid_be_i[1];
    rx_clr     = rd && dev_cmd_i == REG_RX;
    ovf_set    = push && full && !pop;
    en_d       = (wr && dev_cmd_i == REG_CTRL && dev_wvalid_be_i[0]) ? dev_wdata_i[CTRL_EN] : en_q;
    ovf_d      = ovf_set || (ovf_q && !(w1c && dev_wdata_i[ST_OVF]));
    nack_d     = (rsp_valid_i && rsp_nack_i) || (nack_q && !(w1c && dev_wdata_i[ST_NACK]));
    rx_ovr_d   = (rsp_valid_i && rx_valid_q && !rx_clr) || (rx_ovr_q && !(w1c && dev_wdata_i[ST_RX_OVR]));
    rx_valid_d = rsp_valid_i || (rx_valid_q && !rx_clr);
    rx_byte_d  = rsp_valid_i ? rsp_data_i : rx_byte_q;
    status = '0;
    status[ST_EMPTY]    = empty;
    status[ST_FULL]     = full;
    status[ST_BUSY]     = busy_i;
    status[ST_RX_VALID] = rx_valid_q;
    status[ST_OVF]      = ovf_q;
    status[ST_NACK]     = nack_q;
    status[ST_RX_OVR]   = rx_ovr_q;
    reg_val = dev_cmd_i == REG_ID       ? ID_WORD :
              dev_cmd_i == REG_CTRL     ? {31'b0, en_q} :
              dev_cmd_i == REG_STATUS   ? status :
              dev_cmd_i == REG_RX       ? {rx_valid_q, 23'b0, rx_byte_q} :
              dev_cmd_i == REG_LEVEL    ? 32'(level) :
              dev_cmd_i == REG_IRQ_MASK ? mask_rd : '0;
    rdata_d = dev_rvalid_i ? (sel ? reg_val : '0) : rdata_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q    <= '0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      nack_q     <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      nack_q     <= nack_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
    end
  end
`ifdef SCCB_CMD_REGS_IRQ_EN
  logic [3:0] mask_q, mask_d;
  logic irq_q, irq_d;
  assign mask_rd = {28'b0, mask_q};
  assign irq_o   = irq_q;
  always_comb begin
    mask_d = (wr && dev_cmd_i == REG_IRQ_MASK && dev_wvalid_be_i[0]) ? dev_wdata_i[3:0] : mask_q;
    irq_d  = |(mask_q & {rx_valid_q, nack_q, ovf_q, empty && !busy_i});
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end
`else
  assign mask_rd = '0;
`endif
endmodule
